timer_cnt_ctrl: RTL



---
 rtl/timer_cnt_ctrl.sv | 115 +++++++++++
 1 files changed

// File: rtl/timer_cnt_ctrl.sv
// Timer counter sequencer: run/idle/halt FSM, 2^n prescaler, loadable counter,
// compare-match and sticky interrupt status. Debug halt support: TIMER_DBG_HALT_EN.
module timer_cnt_ctrl #(
   parameter int CNT_W   = 64,
   parameter int DIV_MAX = 8
) (
   input  logic             pclk,
   input  logic             prst_n,
   input  logic             timer_en,
   input  logic             div_en,
   input  logic [3:0]       div_val,
   input  logic             halt_req,
   output logic             halt_ack,
   input  logic             cnt_load,
   input  logic [CNT_W-1:0] cnt_load_val,
   input  logic [CNT_W-1:0] cmp_val,
   input  logic             int_en,
   input  logic             int_clr,
   output logic [CNT_W-1:0] cnt,
   output logic             cnt_en,
   output logic             int_st,
   output logic             tim_int
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HALT = 2'd2
   } state_t;

   localparam logic [3:0] DIV_MAX_L = 4'(DIV_MAX);

   state_t           state;
   logic [7:0]       div_cnt;
   logic [3:0]       eff;
   logic [8:0]       term;
   logic             halt_live;
   logic             match;
   logic             match_q;
   logic             set_pulse;

`ifdef TIMER_DBG_HALT_EN
   assign halt_live = halt_req;
`else
   // Halt request is gated off so the HALT state folds away in synthesis.
   assign halt_live = halt_req & 1'b0;
`endif

   always_comb begin
      eff = 4'd0;
      if (div_en) begin
         eff = (div_val > DIV_MAX_L) ? DIV_MAX_L : div_val;
      end
   end

   assign term     = (9'd1 << eff) - 9'd1;
   // >= so that lowering div_val mid-period wraps at once instead of stalling.
   assign cnt_en   = (state == RUN) && ({1'b0, div_cnt} >= term);
   assign halt_ack = (state == HALT);

   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         state   <= IDLE;
         div_cnt <= 8'd0;
      end else begin
         case (state)
            IDLE: begin
               div_cnt <= 8'd0;
               if (timer_en) state <= RUN;
            end
            RUN: begin
               div_cnt <= cnt_en ? 8'd0 : div_cnt + 8'd1;
               if (!timer_en)      state <= IDLE;
               else if (halt_live) state <= HALT;
            end
            HALT: begin
               if (!timer_en)       state <= IDLE;
               else if (!halt_live) state <= RUN;
            end
            default: begin
               state   <= IDLE;
               div_cnt <= 8'd0;
            end
         endcase
      end
   end

   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         cnt <= '0;
      end else if (cnt_load) begin
         cnt <= cnt_load_val;
      end else if (cnt_en) begin
         cnt <= cnt + 1'b1;
      end
   end

   // Edge-based set: a counter parked on cmp_val can be cleared without re-firing.
   assign match     = (cnt == cmp_val);
   assign set_pulse = match & ~match_q;

   always_ff @(posedge pclk or negedge prst_n) begin
      if (!prst_n) begin
         match_q <= 1'b0;
         int_st  <= 1'b0;
      end else begin
         match_q <= match;
         if (set_pulse)    int_st <= 1'b1;
         else if (int_clr) int_st <= 1'b0;
      end
   end

   assign tim_int = int_st & int_en;

endmodule
